// File: rtl/mem_block_copy_if.sv
// rtl/mem_block_copy_if.sv - memory request/response bus between the block-copy engine and memory
interface mem_block_copy_if #(
    parameter int MEM_AW = 16,
    parameter int MEM_DW = 32
) ();
    logic              mem_req;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_addr;
    logic [MEM_DW-1:0] mem_wdata;
    logic              mem_rdata_vld;
    logic [MEM_DW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata_vld,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata_vld,
        output mem_rdata
    );
endinterface

// File: rtl/mem_block_copy.sv
// rtl/mem_block_copy.sv - 2D strided block copy / fill / invert-copy engine
// Outputs are registered from the next-state view so they line up with the state they belong to.
module mem_block_copy #(
    parameter int MEM_AW   = 16,
    parameter int MEM_DW   = 32,
    parameter int DIM_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [1:0]          mode,
    input  logic                abort,
    input  logic [MEM_AW-1:0]   sBASE,
    input  logic [MEM_AW-1:0]   dBASE,
    input  logic [DIM_BITS-1:0] sSTRIDE,
    input  logic [DIM_BITS-1:0] dSTRIDE,
    input  logic [DIM_BITS-1:0] ROWS,
    input  logic [DIM_BITS-1:0] COLS,
    input  logic [MEM_DW-1:0]   fill_val,
    mem_block_copy_if.master    mem,
    output logic                busy,
    output logic                ret
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t              r_state, w_state_n;
    logic [1:0]          r_mode, w_mode_n;
    logic [DIM_BITS-1:0] r_sstride, w_sstride_n;
    logic [DIM_BITS-1:0] r_dstride, w_dstride_n;
    logic [DIM_BITS-1:0] r_rows, w_rows_n;
    logic [DIM_BITS-1:0] r_cols, w_cols_n;
    logic [MEM_DW-1:0]   r_fill, w_fill_n;
    logic [MEM_DW-1:0]   r_data, w_data_n;
    logic [DIM_BITS-1:0] r_row, w_row_n;
    logic [DIM_BITS-1:0] r_col, w_col_n;
    logic [MEM_AW-1:0]   r_srow, w_srow_n;
    logic [MEM_AW-1:0]   r_drow, w_drow_n;

    logic                r_mem_req, w_mem_req_n;
    logic                r_mem_write, w_mem_write_n;
    logic [MEM_AW-1:0]   r_mem_addr, w_mem_addr_n;
    logic [MEM_DW-1:0]   r_mem_wdata, w_mem_wdata_n;
    logic                r_busy, w_busy_n;
    logic                r_ret, w_ret_n;

    logic                w_last_col;
    logic                w_last;

    assign w_last_col = (r_col == r_cols - DIM_BITS'(1));
    assign w_last     = w_last_col && (r_row == r_rows - DIM_BITS'(1));

    // State register: FSM state, latched configuration, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_sstride   <= '0;
            r_dstride   <= '0;
            r_rows      <= '0;
            r_cols      <= '0;
            r_fill      <= '0;
            r_data      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_srow      <= '0;
            r_drow      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_ret       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_mode      <= w_mode_n;
            r_sstride   <= w_sstride_n;
            r_dstride   <= w_dstride_n;
            r_rows      <= w_rows_n;
            r_cols      <= w_cols_n;
            r_fill      <= w_fill_n;
            r_data      <= w_data_n;
            r_row       <= w_row_n;
            r_col       <= w_col_n;
            r_srow      <= w_srow_n;
            r_drow      <= w_drow_n;
            r_mem_req   <= w_mem_req_n;
            r_mem_write <= w_mem_write_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_wdata <= w_mem_wdata_n;
            r_busy      <= w_busy_n;
            r_ret       <= w_ret_n;
        end
    end

    // Next-state logic, including configuration capture and row/column walking
    always_comb begin
        w_state_n   = r_state;
        w_mode_n    = r_mode;
        w_sstride_n = r_sstride;
        w_dstride_n = r_dstride;
        w_rows_n    = r_rows;
        w_cols_n    = r_cols;
        w_fill_n    = r_fill;
        w_data_n    = r_data;
        w_row_n     = r_row;
        w_col_n     = r_col;
        w_srow_n    = r_srow;
        w_drow_n    = r_drow;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_mode_n    = mode;
                    w_sstride_n = sSTRIDE;
                    w_dstride_n = dSTRIDE;
                    w_rows_n    = ROWS;
                    w_cols_n    = COLS;
                    w_fill_n    = fill_val;
                    w_row_n     = '0;
                    w_col_n     = '0;
                    w_srow_n    = sBASE;
                    w_drow_n    = dBASE;
                    if (ROWS == '0 || COLS == '0) w_state_n = S_DONE;
                    else if (mode == 2'd1)        w_state_n = S_WR;
                    else                          w_state_n = S_RD;
                end
            end
            S_RD: begin
                if (abort) begin
                    w_state_n = S_IDLE;
                end else if (mem.mem_rdata_vld) begin
                    w_data_n  = (r_mode == 2'd2) ? ~mem.mem_rdata : mem.mem_rdata;
                    w_state_n = S_WR;
                end
            end
            S_WR: begin
                if (abort) begin
                    w_state_n = S_IDLE;
                end else begin
                    // Row bases advance by the stride; no multiplier in the address path
                    if (w_last_col) begin
                        w_col_n  = '0;
                        w_row_n  = r_row + DIM_BITS'(1);
                        w_srow_n = r_srow + MEM_AW'(r_sstride);
                        w_drow_n = r_drow + MEM_AW'(r_dstride);
                    end else begin
                        w_col_n  = r_col + DIM_BITS'(1);
                    end
                    if (w_last)                 w_state_n = S_DONE;
                    else if (r_mode == 2'd1)    w_state_n = S_WR;
                    else                        w_state_n = S_RD;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Output logic, evaluated on the next state so the registered outputs match it
    always_comb begin
        w_mem_req_n   = 1'b0;
        w_mem_write_n = 1'b0;
        w_mem_addr_n  = '0;
        w_mem_wdata_n = '0;
        w_busy_n      = (w_state_n != S_IDLE);
        w_ret_n       = (w_state_n == S_DONE);
        case (w_state_n)
            S_RD: begin
                w_mem_req_n  = 1'b1;
                w_mem_addr_n = w_srow_n + MEM_AW'(w_col_n);
            end
            S_WR: begin
                w_mem_req_n   = 1'b1;
                w_mem_write_n = 1'b1;
                w_mem_addr_n  = w_drow_n + MEM_AW'(w_col_n);
                w_mem_wdata_n = (w_mode_n == 2'd1) ? w_fill_n : w_data_n;
            end
            default: ;
        endcase
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_write = r_mem_write;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign busy          = r_busy;
    assign ret           = r_ret;

endmodule

// File: tb/tb_mem_block_copy.sv
// tb/tb_mem_block_copy.sv - directed self-checking bench for mem_block_copy
module tb_mem_block_copy;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [1:0]  mode;
    logic        abort;
    logic [15:0] sbase, dbase, sstride, dstride, rows, cols;
    logic [31:0] fill_val;
    logic        busy, ret;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          go_edge  = 0;
    int          rd_delay = 0;
    int          wcnt     = 0;
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_rdata = 32'h0;

    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [15:0] rd_addr[$];
    int          req_cnt, rd_req_cnt, ret_cnt, ret_cyc;

    mem_block_copy_if #(.MEM_AW(16), .MEM_DW(32)) mem_if ();

    mem_block_copy #(.MEM_AW(16), .MEM_DW(32), .DIM_BITS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .mode     (mode),
        .abort    (abort),
        .sBASE    (sbase),
        .dBASE    (dbase),
        .sSTRIDE  (sstride),
        .dSTRIDE  (dstride),
        .ROWS     (rows),
        .COLS     (cols),
        .fill_val (fill_val),
        .mem      (mem_if),
        .busy     (busy),
        .ret      (ret)
    );

    always #5 clk = ~clk;

    // Memory model: read data is a tag plus the address, valid after rd_delay wait cycles
    assign mem_if.mem_rdata_vld = mem_if.mem_req && !mem_if.mem_write && (wcnt == rd_delay);
    assign mem_if.mem_rdata     = use_fixed ? fixed_rdata : {16'hC0DE, mem_if.mem_addr};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_if.mem_req && !mem_if.mem_write && !mem_if.mem_rdata_vld) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_if.mem_req) req_cnt++;
            if (mem_if.mem_req && !mem_if.mem_write) rd_req_cnt++;
            if (mem_if.mem_req && mem_if.mem_write) begin
                wr_addr.push_back(mem_if.mem_addr);
                wr_data.push_back(mem_if.mem_wdata);
                wr_cyc.push_back(cyc);
            end
            if (mem_if.mem_rdata_vld) rd_addr.push_back(mem_if.mem_addr);
            if (ret) begin
                ret_cnt++;
                ret_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        rd_addr.delete();
        req_cnt    = 0;
        rd_req_cnt = 0;
        ret_cnt    = 0;
        ret_cyc    = -1;
    endtask

    task automatic start(input logic [1:0] m, input logic [15:0] sb, input logic [15:0] ss,
                         input logic [15:0] db, input logic [15:0] ds, input logic [15:0] r,
                         input logic [15:0] c, input logic [31:0] fv);
        mode = m; sbase = sb; sstride = ss; dbase = db; dstride = ds;
        rows = r; cols = c; fill_val = fv;
        go = 1'b1;
        @(posedge clk);
        tick();
        go = 1'b0;
        go_edge = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
        tick();
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; abort = 1'b0; mode = 2'd0;
        sbase = '0; dbase = '0; sstride = '0; dstride = '0; rows = '0; cols = '0; fill_val = '0;
        clr();
        #1;
        check("rst_req",   mem_if.mem_req, 0);
        check("rst_busy",  busy, 0);
        check("rst_ret",   ret, 0);
        check("rst_addr",  mem_if.mem_addr, 0);
        check("rst_wdata", mem_if.mem_wdata, 0);
        tick();

        // Copy, go presented on the first edge after reset release
        rst = 1'b0;
        start(2'd0, 16'h0100, 16'd8, 16'h0200, 16'd4, 16'd2, 16'd3, 32'h0);
        check("first_go_busy", busy, 1);
        wait_idle();
        check("copy_nwr", wr_addr.size(), 6);
        check("copy_nrd", rd_addr.size(), 6);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] s, d;
            s = 16'h0100 + 16'((i / 3) * 8 + (i % 3));
            d = 16'h0200 + 16'((i / 3) * 4 + (i % 3));
            check($sformatf("copy_rd%0d", i), rd_addr[i], s);
            check($sformatf("copy_wa%0d", i), wr_addr[i], d);
            check($sformatf("copy_wd%0d", i), wr_data[i], {16'hC0DE, s});
        end
        check("copy_ret_cnt", ret_cnt, 1);
        check("copy_ret_lat", ret_cyc - go_edge, 12);

        // Fill: back-to-back writes
        clr();
        start(2'd1, 16'h0, 16'd0, 16'h0300, 16'd16, 16'd1, 16'd4, 32'hA5A5A5A5);
        wait_idle();
        check("fill_nwr", wr_addr.size(), 4);
        check("fill_nrd", rd_req_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill_wa%0d", i), wr_addr[i], 16'h0300 + 16'(i));
            check($sformatf("fill_wd%0d", i), wr_data[i], 32'hA5A5A5A5);
            check($sformatf("fill_wc%0d", i), wr_cyc[i] - go_edge, i);
        end
        check("fill_ret_lat", ret_cyc - go_edge, 4);

        // Invert copy with three wait states
        clr();
        use_fixed = 1'b1; fixed_rdata = 32'h0000FFFF; rd_delay = 3;
        start(2'd2, 16'h0040, 16'd0, 16'h0080, 16'd0, 16'd1, 16'd1, 32'h0);
        wait_idle();
        check("inv_rd_cycles", rd_req_cnt, 4);
        check("inv_nwr", wr_addr.size(), 1);
        check("inv_wd", wr_data[0], 32'hFFFF0000);
        check("inv_wa", wr_addr[0], 16'h0080);
        check("inv_ret_lat", ret_cyc - go_edge, 5);
        use_fixed = 1'b0; rd_delay = 0;

        // Zero dimension, go pulsed again while in DONE
        clr();
        start(2'd0, 16'h0, 16'd0, 16'h0, 16'd0, 16'd3, 16'd0, 32'h0);
        check("zero_busy", busy, 1);
        check("zero_ret", ret, 1);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("zero_no_restart", busy, 0);
        wait_idle();
        check("zero_req", req_cnt, 0);
        check("zero_ret_cnt", ret_cnt, 1);

        // go and config changes while busy must not disturb the running copy
        clr();
        start(2'd0, 16'h0400, 16'd0, 16'h0500, 16'd0, 16'd1, 16'd2, 32'h0);
        go = 1'b1; mode = 2'd1; sbase = 16'h0900; dbase = 16'h0980; cols = 16'd5;
        tick();
        go = 1'b0;
        wait_idle();
        check("busy_nwr", wr_addr.size(), 2);
        check("busy_wa1", wr_addr[1], 16'h0501);
        check("busy_wd1", wr_data[1], {16'hC0DE, 16'h0401});
        check("busy_ret_cnt", ret_cnt, 1);

        // Destination address wrap-around
        clr();
        start(2'd1, 16'h0, 16'd0, 16'hFFFE, 16'd0, 16'd1, 16'd4, 32'h12345678);
        wait_idle();
        check("wrap_wa0", wr_addr[0], 16'hFFFE);
        check("wrap_wa1", wr_addr[1], 16'hFFFF);
        check("wrap_wa2", wr_addr[2], 16'h0000);
        check("wrap_wa3", wr_addr[3], 16'h0001);

        // Abort in the second RD
        clr();
        start(2'd0, 16'h0600, 16'd0, 16'h0700, 16'd0, 16'd1, 16'd4, 32'h0);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_req", mem_if.mem_req, 0);
        repeat (4) tick();
        check("abort_nwr", wr_addr.size(), 1);
        check("abort_ret_cnt", ret_cnt, 0);

        // abort together with go in IDLE still starts
        clr();
        abort = 1'b1;
        start(2'd1, 16'h0, 16'd0, 16'h0010, 16'd0, 16'd1, 16'd1, 32'hCAFEF00D);
        abort = 1'b0;
        check("abort_go_busy", busy, 1);
        wait_idle();
        check("abort_go_nwr", wr_addr.size(), 1);

        // Asynchronous reset in the middle of a fill
        clr();
        start(2'd1, 16'h0, 16'd0, 16'h0800, 16'd0, 16'd1, 16'd8, 32'h55AA55AA);
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_req",   mem_if.mem_req, 0);
        check("arst_write", mem_if.mem_write, 0);
        check("arst_addr",  mem_if.mem_addr, 0);
        check("arst_wdata", mem_if.mem_wdata, 0);
        check("arst_busy",  busy, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("arst_ret_cnt", ret_cnt, 0);
        check("arst_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
